// File: rtl/id_fwd_stage.sv
// id_fwd_stage: MIPS decode with EX/MEM/WB operand forwarding,
// ID-resolved branches/jumps, load-use interlock and ID/EX register.
module id_fwd_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc_4,
  input  logic [31:0]     if_instr,
  output logic            id_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_we,
  input  logic            ex_is_load,
  input  logic [RA_W-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_we,
  input  logic [RA_W-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            ex_stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_rs_val,
  output logic [XLEN-1:0] out_rt_val,
  output logic [XLEN-1:0] out_imm,
  output logic [RA_W-1:0] out_wr_addr,
  output logic [3:0]      out_alu_op,
  output logic            out_we,
  output logic            out_mem_we,
  output logic            out_mem_to_reg,
  output logic            out_alu_b_imm,
  output logic            out_shamt_sel,
  output logic            out_illegal,
  output logic [CNT_W-1:0] stall_count
);

  localparam int NREG = 2**RA_W;
  localparam logic [RA_W-1:0] LINK = RA_W'(NREG-1);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  logic [XLEN-1:0] rf [NREG];

  logic [5:0]      op, fn;
  logic [RA_W-1:0] rs, rt, rd;
  assign op = if_instr[31:26];
  assign fn = if_instr[5:0];
  assign rs = RA_W'(if_instr[25:21]);
  assign rt = RA_W'(if_instr[20:16]);
  assign rd = RA_W'(if_instr[15:11]);

  logic r_t;
  logic i_add, i_sub, i_and, i_or, i_slt;
  logic i_sll, i_srl, i_jr;
  logic i_addi, i_andi, i_ori, i_lw, i_sw;
  logic i_beq, i_bne, i_j, i_jal;

  assign r_t    = op == 6'h00;
  assign i_add  = r_t && fn == 6'h20;
  assign i_sub  = r_t && fn == 6'h22;
  assign i_and  = r_t && fn == 6'h24;
  assign i_or   = r_t && fn == 6'h25;
  assign i_slt  = r_t && fn == 6'h2A;
  assign i_sll  = r_t && fn == 6'h00;
  assign i_srl  = r_t && fn == 6'h02;
  assign i_jr   = r_t && fn == 6'h08;
  assign i_addi = op == 6'h08;
  assign i_andi = op == 6'h0C;
  assign i_ori  = op == 6'h0D;
  assign i_lw   = op == 6'h23;
  assign i_sw   = op == 6'h2B;
  assign i_beq  = op == 6'h04;
  assign i_bne  = op == 6'h05;
  assign i_j    = op == 6'h02;
  assign i_jal  = op == 6'h03;

  function automatic logic [XLEN-1:0] fwd(
    input logic [RA_W-1:0] a,
    input logic [XLEN-1:0] arr
  );
    if (a == '0)
      return '0;
    else if (ex_we && !ex_is_load && ex_addr == a)
      return ex_data;
    else if (mem_we && mem_addr == a)
      return mem_data;
    else if (wb_we && wb_addr == a)
      return wb_data;
    else
      return arr;
  endfunction

  logic [XLEN-1:0] rs_v, rt_v;
  always_comb begin
    rs_v = fwd(rs, rf[rs]);
    rt_v = fwd(rt, rf[rt]);
  end

  logic use_rs, use_rt, load_use;
  assign use_rs = !(i_j || i_jal || i_sll || i_srl);
  assign use_rt = r_t || i_sw || i_beq || i_bne;
  assign load_use = if_valid && ex_we && ex_is_load &&
                    ex_addr != '0 &&
                    ((use_rs && ex_addr == rs) ||
                     (use_rt && ex_addr == rt));
  assign id_ready = !load_use && !ex_stall;

  logic [XLEN-1:0] imm_s, imm_z, br_tgt, j_tgt;
  assign imm_s  = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
  assign imm_z  = {{(XLEN-16){1'b0}}, if_instr[15:0]};
  assign br_tgt = if_pc_4 + (imm_s << 2);
  assign j_tgt  = {if_pc_4[XLEN-1:28], if_instr[25:0], 2'b00};

  logic taken;
  assign taken = (i_beq && rs_v == rt_v) ||
                 (i_bne && rs_v != rt_v);
  assign redirect_valid = if_valid && id_ready &&
                          (taken || i_j || i_jal || i_jr);

  always_comb begin
    unique case (1'b1)
      i_jr:         redirect_pc = rs_v;
      i_j || i_jal: redirect_pc = j_tgt;
      default:      redirect_pc = br_tgt;
    endcase
  end

  logic [XLEN-1:0] d_rs, d_rt, d_imm;
  logic [RA_W-1:0] d_wa;
  logic [3:0]      d_op;
  logic d_we, d_mw, d_m2r, d_bimm, d_sh, d_ill;

  always_comb begin
    d_rs   = rs_v;
    d_rt   = rt_v;
    d_imm  = imm_s;
    d_wa   = r_t ? rd : rt;
    d_op   = ALU_ADD;
    d_we   = 1'b0;
    d_mw   = 1'b0;
    d_m2r  = 1'b0;
    d_bimm = 1'b0;
    d_sh   = 1'b0;
    d_ill  = 1'b0;
    unique case (1'b1)
      i_add: d_we = 1'b1;
      i_sub: begin d_op = ALU_SUB; d_we = 1'b1; end
      i_and: begin d_op = ALU_AND; d_we = 1'b1; end
      i_or:  begin d_op = ALU_OR;  d_we = 1'b1; end
      i_slt: begin d_op = ALU_SLT; d_we = 1'b1; end
      i_sll: begin
        d_op = ALU_SLL; d_we = 1'b1; d_sh = 1'b1;
      end
      i_srl: begin
        d_op = ALU_SRL; d_we = 1'b1; d_sh = 1'b1;
      end
      i_jr, i_j: begin end
      i_addi: begin d_we = 1'b1; d_bimm = 1'b1; end
      i_andi: begin
        d_op = ALU_AND; d_imm = imm_z;
        d_we = 1'b1; d_bimm = 1'b1;
      end
      i_ori: begin
        d_op = ALU_OR; d_imm = imm_z;
        d_we = 1'b1; d_bimm = 1'b1;
      end
      i_lw: begin
        d_we = 1'b1; d_bimm = 1'b1; d_m2r = 1'b1;
      end
      i_sw: begin d_mw = 1'b1; d_bimm = 1'b1; end
      i_beq, i_bne: d_op = ALU_SUB;
      i_jal: begin
        d_rs = if_pc_4; d_rt = '0;
        d_wa = LINK; d_we = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      out_rs_val     <= '0;
      out_rt_val     <= '0;
      out_imm        <= '0;
      out_wr_addr    <= '0;
      out_alu_op     <= '0;
      out_we         <= 1'b0;
      out_mem_we     <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_alu_b_imm  <= 1'b0;
      out_shamt_sel  <= 1'b0;
      out_illegal    <= 1'b0;
      stall_count    <= '0;
    end else if (!ex_stall) begin
      if (load_use) begin
        out_valid      <= 1'b0;
        out_rs_val     <= '0;
        out_rt_val     <= '0;
        out_imm        <= '0;
        out_wr_addr    <= '0;
        out_alu_op     <= '0;
        out_we         <= 1'b0;
        out_mem_we     <= 1'b0;
        out_mem_to_reg <= 1'b0;
        out_alu_b_imm  <= 1'b0;
        out_shamt_sel  <= 1'b0;
        out_illegal    <= 1'b0;
        if (stall_count != '1)
          stall_count <= stall_count + CNT_W'(1);
      end else begin
        out_valid      <= if_valid;
        out_rs_val     <= d_rs;
        out_rt_val     <= d_rt;
        out_imm        <= d_imm;
        out_wr_addr    <= d_wa;
        out_alu_op     <= d_op;
        out_we         <= d_we;
        out_mem_we     <= d_mw;
        out_mem_to_reg <= d_m2r;
        out_alu_b_imm  <= d_bimm;
        out_shamt_sel  <= d_sh;
        out_illegal    <= d_ill;
      end
    end
  end

endmodule
